// File: rtl/mmss_bcd_timer_pkg.sv
// Shared types and constants for the MM:SS BCD timer.
// Ports: none (package: state encoding, digit limits, clamp helper).
package mmss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_PAUSE = 2'(PAUSE);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] v,
    input logic [3:0] mx
  );
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/mmss_bcd_timer_if.sv
// Control/status bundle of the MM:SS timer.
// master: drives start/stop/clear/load/ld_*/count_down; slave: drives digits+flags.
interface mmss_bcd_timer_if;

  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [3:0] ld_minute_tens;
  logic [3:0] ld_minute_unit;
  logic [3:0] ld_second_tens;
  logic [3:0] ld_second_unit;
  logic       count_down;

  logic [3:0] minute_tens;
  logic [3:0] minute_unit;
  logic [3:0] second_tens;
  logic [3:0] second_unit;
  logic       running;
  logic       sec_tick;
  logic       expired;
  logic       wrapped;

  modport master (
    output start, stop, clear, load,
    output ld_minute_tens, ld_minute_unit,
    output ld_second_tens, ld_second_unit,
    output count_down,
    input  minute_tens, minute_unit,
    input  second_tens, second_unit,
    input  running, sec_tick, expired, wrapped
  );

  modport slave (
    input  start, stop, clear, load,
    input  ld_minute_tens, ld_minute_unit,
    input  ld_second_tens, ld_second_unit,
    input  count_down,
    output minute_tens, minute_unit,
    output second_tens, second_unit,
    output running, sec_tick, expired, wrapped
  );

endinterface

// File: rtl/mmss_bcd_timer_digit.sv
// One BCD digit, up/down with carry/borrow chain, sync clear and clamped load.
// Ports: clk, rst_n, clr_i, ld_i, ld_val_i, dn_i, cin_i, q_o, cout_o.
module bcd_digit_counter
  import mmss_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       dn_i,
  input  logic       cin_i,
  output logic [3:0] q_o,
  output logic       cout_o
);

  logic [3:0] q_q, q_d;
  logic       at_edge;

  // Rolling edge: MAX when counting up, 0 when counting down.
  assign at_edge = dn_i ? (q_q == 4'd0) : (q_q == MAX);
  assign cout_o  = cin_i & at_edge;
  assign q_o     = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (ld_i) begin
      q_d = bcd_clamp(ld_val_i, MAX);
    end else if (cin_i) begin
      if (at_edge) q_d = dn_i ? MAX : 4'd0;
      else         q_d = dn_i ? q_q - 4'd1 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/mmss_bcd_timer.sv
// MM:SS BCD timer: 1 s prescaler, IDLE/RUN/PAUSE/DONE control, 4 chained digits.
// Ports: clk, rst_n, bus (slave: controls in, digits/running/pulses out).
module mmss_bcd_timer
  import mmss_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  mmss_bcd_timer_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       st_q, st_d;
  logic             tick_q, tick_d;
  logic             exp_q, exp_d;
  logic             wrap_q, wrap_d;

  logic [3:0] su, stn, mu, mtn;
  logic       c_su, c_st, c_mu, c_mt;

  logic is_run, at_last, tick, down;
  logic time_zero, one_sec;
  logic step_en, expire_now;
  logic reinit, stop_go, run_go, start_go;
  logic done_hold;

  assign is_run  = (st_q == ST_RUN);
  assign at_last = (cnt_q == CNT_LAST);
  assign down    = bus.count_down;

  assign time_zero = (mtn == 4'd0) && (mu == 4'd0) &&
                     (stn == 4'd0) && (su == 4'd0);
  assign one_sec   = (mtn == 4'd0) && (mu == 4'd0) &&
                     (stn == 4'd0) && (su == 4'd1);

  // Priority clear > load > stop > start, made one-hot.
  assign reinit   = bus.clear | bus.load;
  assign stop_go  = !reinit & bus.stop;
  assign run_go   = !reinit & !bus.stop & is_run;
  assign start_go = !reinit & !bus.stop & !is_run & bus.start;

  assign tick       = run_go & at_last;
  // A down tick from 00:00 only expires; it never steps the digits.
  assign step_en    = tick & !(down & time_zero);
  assign expire_now = tick & down & (time_zero | one_sec);
  assign done_hold  = (st_q == ST_DONE) & down & time_zero;

  always_comb begin
    cnt_d  = cnt_q;
    st_d   = st_q;
    tick_d = step_en;
    exp_d  = expire_now;
    wrap_d = step_en & !down & c_mt;
    unique case (1'b1)
      reinit: begin
        cnt_d = '0;
        st_d  = ST_IDLE;
      end
      stop_go: begin
        if (is_run) st_d = ST_PAUSE;
      end
      run_go: begin
        if (at_last) begin
          cnt_d = '0;
          if (expire_now) st_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      start_go: begin
        if (!done_hold) st_d = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      st_q   <= ST_IDLE;
      tick_q <= 1'b0;
      exp_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      tick_q <= tick_d;
      exp_q  <= exp_d;
      wrap_q <= wrap_d;
    end
  end

  bcd_digit_counter #(.MAX(UNIT_MAX)) u_su (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (bus.load),
    .ld_val_i (bus.ld_second_unit),
    .dn_i     (down),
    .cin_i    (step_en),
    .q_o      (su),
    .cout_o   (c_su)
  );

  bcd_digit_counter #(.MAX(TENS_MAX)) u_st (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (bus.load),
    .ld_val_i (bus.ld_second_tens),
    .dn_i     (down),
    .cin_i    (c_su),
    .q_o      (stn),
    .cout_o   (c_st)
  );

  bcd_digit_counter #(.MAX(UNIT_MAX)) u_mu (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (bus.load),
    .ld_val_i (bus.ld_minute_unit),
    .dn_i     (down),
    .cin_i    (c_st),
    .q_o      (mu),
    .cout_o   (c_mu)
  );

  bcd_digit_counter #(.MAX(TENS_MAX)) u_mt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (bus.load),
    .ld_val_i (bus.ld_minute_tens),
    .dn_i     (down),
    .cin_i    (c_mu),
    .q_o      (mtn),
    .cout_o   (c_mt)
  );

  assign bus.minute_tens = mtn;
  assign bus.minute_unit = mu;
  assign bus.second_tens = stn;
  assign bus.second_unit = su;
  assign bus.running     = is_run;
  assign bus.sec_tick    = tick_q;
  assign bus.expired     = exp_q;
  assign bus.wrapped     = wrap_q;

endmodule

// File: tb/tb_mmss_bcd_timer.sv
// Bench for mmss_bcd_timer: directed literal checks plus random stimulus
// compared every cycle against a seconds-based reference model.
module tb_mmss_bcd_timer;

  localparam int TD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int t;
    int pre;
    int st;
    bit tk;
    bit ex;
    bit wr;
  } mstate_t;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   errors;
  int   checks;

  mmss_bcd_timer_if bus ();

  mmss_bcd_timer #(
    .TICK_DIV (TD),
    .CNT_W    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mstate_t m = '{t: 0, pre: 0, st: M_IDLE, tk: 0, ex: 0, wr: 0};

  function automatic int clampv(input logic [3:0] v, input int mx);
    return (int'(v) > mx) ? mx : int'(v);
  endfunction

  function automatic mstate_t nxt(input mstate_t s);
    mstate_t n;
    n    = s;
    n.tk = 0;
    n.ex = 0;
    n.wr = 0;
    if (bus.clear) begin
      n.t = 0; n.pre = 0; n.st = M_IDLE;
    end else if (bus.load) begin
      n.t = 60 * (10 * clampv(bus.ld_minute_tens, 5) +
                  clampv(bus.ld_minute_unit, 9)) +
            10 * clampv(bus.ld_second_tens, 5) +
            clampv(bus.ld_second_unit, 9);
      n.pre = 0; n.st = M_IDLE;
    end else if (bus.stop) begin
      if (s.st == M_RUN) n.st = M_PAUSE;
    end else if (s.st == M_RUN) begin
      if (s.pre == TD - 1) begin
        n.pre = 0;
        if (bus.count_down) begin
          if (s.t == 0) begin
            n.st = M_DONE; n.ex = 1;
          end else begin
            n.t = s.t - 1; n.tk = 1;
            if (n.t == 0) begin
              n.ex = 1; n.st = M_DONE;
            end
          end
        end else begin
          n.t  = (s.t + 1) % 3600;
          n.tk = 1;
          n.wr = (n.t == 0);
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end else if (bus.start) begin
      if (!(s.st == M_DONE && bus.count_down && s.t == 0))
        n.st = M_RUN;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{t: 0, pre: 0, st: M_IDLE, tk: 0, ex: 0, wr: 0};
    else        m <= nxt(m);
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.minute_tens", int'(bus.minute_tens), m.t / 600);
      check("m.minute_unit", int'(bus.minute_unit), (m.t / 60) % 10);
      check("m.second_tens", int'(bus.second_tens), (m.t % 60) / 10);
      check("m.second_unit", int'(bus.second_unit), m.t % 10);
      check("m.running", int'(bus.running), int'(m.st == M_RUN));
      check("m.sec_tick", int'(bus.sec_tick), int'(m.tk));
      check("m.expired", int'(bus.expired), int'(m.ex));
      check("m.wrapped", int'(bus.wrapped), int'(m.wr));
    end
  end

  task automatic chk_time(input string nm, input int a, input int b,
                          input int c, input int d);
    check({nm, ".mt"}, int'(bus.minute_tens), a);
    check({nm, ".mu"}, int'(bus.minute_unit), b);
    check({nm, ".st"}, int'(bus.second_tens), c);
    check({nm, ".su"}, int'(bus.second_unit), d);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d);
    bus.ld_minute_tens = 4'(a);
    bus.ld_minute_unit = 4'(b);
    bus.ld_second_tens = 4'(c);
    bus.ld_second_unit = 4'(d);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int mode;
    errors = 0;
    checks = 0;
    chk_en = 0;
    rst_n  = 1'b0;
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    bus.count_down = 0;
    bus.ld_minute_tens = 0; bus.ld_minute_unit = 0;
    bus.ld_second_tens = 0; bus.ld_second_unit = 0;
    wait_n(2);
    rst_n  = 1'b1;
    chk_en = 1;
    chk_time("reset", 0, 0, 0, 0);
    check("reset.running", int'(bus.running), 0);
    check("reset.sec_tick", int'(bus.sec_tick), 0);

    // Up count 00:58 -> 00:59 -> 01:00
    do_load(0, 0, 5, 8);
    chk_time("ld0058", 0, 0, 5, 8);
    pulse_start();
    check("up.running", int'(bus.running), 1);
    wait_n(3);
    chk_time("up.pre", 0, 0, 5, 8);
    wait_n(1);
    chk_time("up.s1", 0, 0, 5, 9);
    check("up.tick1", int'(bus.sec_tick), 1);
    wait_n(4);
    chk_time("up.s2", 0, 1, 0, 0);
    check("up.tick2", int'(bus.sec_tick), 1);

    // Wrap 59:59 -> 00:00
    do_load(5, 9, 5, 9);
    pulse_start();
    wait_n(4);
    chk_time("wrap", 0, 0, 0, 0);
    check("wrap.pulse", int'(bus.wrapped), 1);
    check("wrap.running", int'(bus.running), 1);
    wait_n(1);
    check("wrap.once", int'(bus.wrapped), 0);

    // Down count and expiry
    bus.count_down = 1'b1;
    do_load(0, 1, 0, 0);
    pulse_start();
    wait_n(4);
    chk_time("down", 0, 0, 5, 9);
    do_load(0, 0, 0, 1);
    pulse_start();
    wait_n(4);
    chk_time("exp", 0, 0, 0, 0);
    check("exp.pulse", int'(bus.expired), 1);
    check("exp.running", int'(bus.running), 0);
    pulse_start();
    check("done.running", int'(bus.running), 0);
    wait_n(4);
    check("done.noexp", int'(bus.expired), 0);
    check("done.stay", int'(bus.running), 0);

    // Clamped load
    do_load(15, 7, 12, 9);
    chk_time("clamp", 5, 7, 5, 9);

    // Stop at prescaler 2, resume, then clear on a tick
    bus.count_down = 1'b0;
    do_load(0, 0, 1, 0);
    pulse_start();
    wait_n(2);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop.running", int'(bus.running), 0);
    wait_n(10);
    chk_time("stop.frozen", 0, 0, 1, 0);
    pulse_start();
    check("resume.running", int'(bus.running), 1);
    wait_n(1);
    chk_time("resume.pre", 0, 0, 1, 0);
    wait_n(1);
    chk_time("resume.step", 0, 0, 1, 1);
    check("resume.tick", int'(bus.sec_tick), 1);
    wait_n(3);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk_time("clr.tick", 0, 0, 0, 0);
    check("clr.notick", int'(bus.sec_tick), 0);
    check("clr.running", int'(bus.running), 0);

    // Asynchronous reset mid-run at 12:34
    do_load(1, 2, 3, 4);
    pulse_start();
    wait_n(2);
    #2 rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0, 0);
    check("arst.running", int'(bus.running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    repeat (3000) begin
      @(negedge clk);
      bus.clear = ($urandom_range(0, 59) == 0);
      bus.load  = ($urandom_range(0, 29) == 0);
      bus.stop  = ($urandom_range(0, 19) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) bus.count_down = ~bus.count_down;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          bus.ld_minute_tens = 4'($urandom_range(0, 15));
          bus.ld_minute_unit = 4'($urandom_range(0, 15));
          bus.ld_second_tens = 4'($urandom_range(0, 15));
          bus.ld_second_unit = 4'($urandom_range(0, 15));
        end
        1: begin
          bus.ld_minute_tens = 4'd5; bus.ld_minute_unit = 4'd9;
          bus.ld_second_tens = 4'd5; bus.ld_second_unit = 4'd7;
        end
        2: begin
          bus.ld_minute_tens = 4'd0; bus.ld_minute_unit = 4'd0;
          bus.ld_second_tens = 4'd0; bus.ld_second_unit = 4'd2;
        end
        default: begin
          bus.ld_minute_tens = 4'd0; bus.ld_minute_unit = 4'd1;
          bus.ld_second_tens = 4'd0; bus.ld_second_unit = 4'd0;
        end
      endcase
    end

    @(negedge clk);
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    wait_n(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
